// File: rtl/fir_frame_seq.sv
// fir_frame_seq: sequences one frame of FRAME_LEN samples into an external FIR and packs its outputs into blocks.
// Latency: the FIR sees each sample one cycle after acceptance; blk_valid follows the closing capture by one cycle.
// Backpressure: none. The FIR cannot stall, so FILL takes one sample per cycle and inserts zeros when in_valid is low.
//
// Ports:
//   clk, rst              single clock, asynchronous active-high reset
//   start                 frame request, honoured only in IDLE
//   in_valid/in_data      input sample stream (signed Q7.8); in_ready is high exactly in FILL
//   fir_clr               one-cycle FIR clear pulse, issued in CLR
//   data_valid/data       registered sample stream driven into the FIR
//   fir_valid/fir_d       FIR output stream, captured only in FILL and FLUSH
//   blk_valid/blk_data/blk_idx   completed block (word k = k-th output, k=0 oldest) and its index
//   frame_done            one-cycle pulse in DONE, coincident with the final blk_valid
//   busy                  high whenever the FSM is not in IDLE
//   underrun              sticky flag, set by any FILL cycle with in_valid low, cleared in CLR
module fir_frame_seq #(
  parameter int FRAME_LEN = 1024,
  parameter int BLK_LEN   = 16,
  localparam int NBLK  = FRAME_LEN / BLK_LEN,
  localparam int IDX_W = (NBLK > 1) ? $clog2(NBLK) : 1,
  localparam int BLK_W = 16 * BLK_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              fir_clr,
  output logic              data_valid,
  output logic [15:0]       data,
  input  logic              fir_valid,
  input  logic [15:0]       fir_d,
  output logic              blk_valid,
  output logic [BLK_W-1:0]  blk_data,
  output logic [IDX_W-1:0]  blk_idx,
  output logic              frame_done,
  output logic              busy,
  output logic              underrun
);

  // One extra bit so the output counter can hold FRAME_LEN itself without wrapping.
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam int PK_W  = (BLK_LEN > 1) ? $clog2(BLK_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FILL,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [PK_W-1:0]    pk_cnt_q, pk_cnt_d;
  logic [IDX_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [BLK_W-1:0]   pack_q, pack_d;
  logic [BLK_W-1:0]   blk_data_q, blk_data_d;
  logic [IDX_W-1:0]   blk_idx_q, blk_idx_d;
  logic               blk_valid_q, blk_valid_d;
  logic [15:0]        data_q, data_d;
  logic               data_valid_q, data_valid_d;
  logic               underrun_q, underrun_d;

  logic               capture;
  logic [BLK_W-1:0]   pack_shift;

  // Outputs are captured only while the frame is running and never beyond FRAME_LEN.
  assign capture = ((state_q == S_FILL) || (state_q == S_FLUSH)) && fir_valid &&
                   (out_cnt_q != CNT_W'(FRAME_LEN));

  // New output enters at the top word, so after BLK_LEN shifts the oldest sits in word 0.
  assign pack_shift = BLK_W'({fir_d, pack_q} >> 16);

  always_comb begin
    state_d      = state_q;
    smp_cnt_d    = smp_cnt_q;
    out_cnt_d    = out_cnt_q;
    pk_cnt_d     = pk_cnt_q;
    blk_cnt_d    = blk_cnt_q;
    pack_d       = pack_q;
    blk_data_d   = blk_data_q;
    blk_idx_d    = blk_idx_q;
    blk_valid_d  = 1'b0;
    data_d       = 16'd0;
    data_valid_d = 1'b0;
    underrun_d   = underrun_q;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLR;
      end
      S_CLR: begin
        smp_cnt_d  = '0;
        out_cnt_d  = '0;
        pk_cnt_d   = '0;
        blk_cnt_d  = '0;
        pack_d     = '0;
        underrun_d = 1'b0;
        state_d    = S_FILL;
      end
      S_FILL: begin
        // The FIR is fed every cycle; a missing sample becomes a zero.
        data_valid_d = 1'b1;
        if (in_valid) begin
          data_d = in_data;
        end else begin
          underrun_d = 1'b1;
        end
        smp_cnt_d = smp_cnt_q + 1'b1;
        if (smp_cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (capture) begin
      pack_d    = pack_shift;
      out_cnt_d = out_cnt_q + 1'b1;
      if (pk_cnt_q == PK_W'(BLK_LEN - 1)) begin
        pk_cnt_d    = '0;
        blk_valid_d = 1'b1;
        blk_data_d  = pack_shift;
        blk_idx_d   = blk_cnt_q;
        blk_cnt_d   = blk_cnt_q + 1'b1;
      end else begin
        pk_cnt_d = pk_cnt_q + 1'b1;
      end
      // The last output closes the frame, even if it lands while still in FILL.
      if (out_cnt_q == CNT_W'(FRAME_LEN - 1)) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      smp_cnt_q    <= '0;
      out_cnt_q    <= '0;
      pk_cnt_q     <= '0;
      blk_cnt_q    <= '0;
      pack_q       <= '0;
      blk_data_q   <= '0;
      blk_idx_q    <= '0;
      blk_valid_q  <= 1'b0;
      data_q       <= 16'd0;
      data_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_cnt_q    <= smp_cnt_d;
      out_cnt_q    <= out_cnt_d;
      pk_cnt_q     <= pk_cnt_d;
      blk_cnt_q    <= blk_cnt_d;
      pack_q       <= pack_d;
      blk_data_q   <= blk_data_d;
      blk_idx_q    <= blk_idx_d;
      blk_valid_q  <= blk_valid_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      underrun_q   <= underrun_d;
    end
  end

  assign in_ready   = (state_q == S_FILL);
  assign fir_clr    = (state_q == S_CLR);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign blk_valid  = blk_valid_q;
  assign blk_data   = blk_data_q;
  assign blk_idx    = blk_idx_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_fir_frame_seq.sv
// Bench for fir_frame_seq: drives frames, models a 2-tap FIR (y[n] = x[n] + x[n-1], 1-cycle latency),
// queues expected FIR input samples and blocks at stimulus time, and a negedge monitor pops and compares.
module tb_fir_frame_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic         in_valid;
  logic [15:0]  in_data;
  logic         in_ready;
  logic         fir_clr;
  logic         data_valid;
  logic [15:0]  data;
  logic         fir_valid;
  logic [15:0]  fir_d;
  logic         blk_valid;
  logic [255:0] blk_data;
  logic [5:0]   blk_idx;
  logic         frame_done;
  logic         busy;
  logic         underrun;

  int checks;
  int errors;
  int done_cnt;

  logic [15:0]  dq[$];
  logic [255:0] bq[$];
  logic [5:0]   iq[$];

  // FIR model state
  logic         const_mode;
  logic         m_vld;
  logic [15:0]  m_y;
  logic [15:0]  m_prev;

  fir_frame_seq #(.FRAME_LEN(1024), .BLK_LEN(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fir_clr    (fir_clr),
    .data_valid (data_valid),
    .data       (data),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .blk_valid  (blk_valid),
    .blk_data   (blk_data),
    .blk_idx    (blk_idx),
    .frame_done (frame_done),
    .busy       (busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural FIR, cleared by rst or fir_clr as at integration.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_vld  <= 1'b0;
      m_y    <= 16'd0;
      m_prev <= 16'd0;
    end else if (fir_clr) begin
      m_vld  <= 1'b0;
      m_y    <= 16'd0;
      m_prev <= 16'd0;
    end else begin
      m_vld <= data_valid;
      if (data_valid) begin
        m_y    <= data + m_prev;
        m_prev <= data;
      end
    end
  end

  assign fir_valid = m_vld;
  assign fir_d     = const_mode ? 16'h0100 : m_y;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] xin(input int n, input bit drop);
    if (drop && n >= 300 && n <= 302) return 16'd0;
    return 16'(n);
  endfunction

  function automatic logic [15:0] yv(input int n, input bit drop);
    if (n == 0) return xin(0, drop);
    return xin(n, drop) + xin(n - 1, drop);
  endfunction

  // Monitor: pops expectations whenever the DUT presents an output.
  logic [15:0]  exp_d;
  logic [255:0] exp_b;
  logic [5:0]   exp_i;
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        if (dq.size() == 0) chk("data_unexpected", 512'(1), 512'(0));
        else begin
          exp_d = dq.pop_front();
          chk("data", 512'(data), 512'(exp_d));
        end
      end
      if (blk_valid) begin
        if (bq.size() == 0) chk("blk_unexpected", 512'(1), 512'(0));
        else begin
          exp_b = bq.pop_front();
          exp_i = iq.pop_front();
          chk("blk_data", 512'(blk_data), 512'(exp_b));
          chk("blk_idx", 512'(blk_idx), 512'(exp_i));
        end
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_with_blk_valid", 512'(blk_valid), 512'(1));
        chk("done_blk_idx", 512'(blk_idx), 512'(63));
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, 512'({in_ready, fir_clr, data_valid, data, blk_valid, blk_idx, frame_done, busy, underrun}), 512'(0));
    chk({name, "_blk_data"}, 512'(blk_data), 512'(0));
  endtask

  // One frame: start pulse, CLR, FILL (optionally with drops, a stray start, or a reset at sample rst_at).
  task automatic run_frame(input bit drop, input bit cst, input bit start_in_fill, input int rst_at, input bit prev_ur);
    int nblk;
    int done0;
    bit got;
    bit aborted;
    logic [255:0] v;
    nblk    = (rst_at < 0) ? 64 : (rst_at - 3) / 16;
    done0   = done_cnt;
    aborted = 1'b0;
    const_mode = cst;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 16; j++) v[16*j +: 16] = cst ? 16'h0100 : yv(16*b + j, drop);
      bq.push_back(v);
      iq.push_back(6'(b));
    end

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("clr_fir_clr", 512'(fir_clr), 512'(1));
    chk("clr_in_ready", 512'(in_ready), 512'(0));
    chk("clr_busy", 512'(busy), 512'(1));
    chk("clr_underrun_old", 512'(underrun), 512'(prev_ur));
    @(posedge clk); #1;
    chk("fill_fir_clr", 512'(fir_clr), 512'(0));
    chk("fill_busy", 512'(busy), 512'(1));

    for (int i = 0; i < 1024; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid_frame");
        aborted = 1'b1;
        break;
      end
      in_valid = !(drop && i >= 300 && i <= 302);
      in_data  = 16'(i);
      start    = start_in_fill && (i == 100);
      dq.push_back(in_valid ? 16'(i) : 16'd0);
      chk("fill_in_ready", 512'(in_ready), 512'(1));
      chk("fill_underrun", 512'(underrun), 512'(drop && i > 300));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    start    = 1'b0;

    if (aborted) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        chk_all_zero("rst_held");
      end
      dq.delete();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        chk("rst_after_busy", 512'(busy), 512'(0));
      end
      chk("rst_no_frame_done", 512'(done_cnt), 512'(done0));
      chk("rst_blocks_emitted", 512'(bq.size()), 512'(0));
      return;
    end

    chk("flush_in_ready", 512'(in_ready), 512'(0));
    chk("flush_busy", 512'(busy), 512'(1));
    chk("flush_underrun", 512'(underrun), 512'(drop));

    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    chk("frame_done_seen", 512'(got), 512'(1));
    chk("done_underrun", 512'(underrun), 512'(drop));
    @(negedge clk); #1;
    chk("frame_done_count", 512'(done_cnt), 512'(done0 + 1));
    chk("blocks_left", 512'(bq.size()), 512'(0));
    chk("samples_left", 512'(dq.size()), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 16'd0;
    const_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("after_reset");

    run_frame(1'b0, 1'b0, 1'b0, -1, 1'b0);   // ramp, identity-free 2-tap FIR
    run_frame(1'b1, 1'b0, 1'b0, -1, 1'b0);   // three dropped samples, back-to-back
    run_frame(1'b0, 1'b1, 1'b1, -1, 1'b1);   // constant FIR output, stray start in FILL
    run_frame(1'b0, 1'b0, 1'b0, 500, 1'b0);  // reset at sample 500
    run_frame(1'b0, 1'b0, 1'b0, -1, 1'b0);   // fresh frame after reset

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
